// File: rtl/cla_nibble_sequencer_pkg.sv
// rtl/cla_nibble_sequencer_pkg.sv - shared constants for the nibble-serial lookahead adder
package cla_nibble_sequencer_pkg;

   localparam int NIB_W = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/cla_nibble_sequencer_cla4_slice.sv
// rtl/cla_nibble_sequencer_cla4_slice.sv - combinational 4-bit carry-lookahead adder slice
module cla4_slice
   import cla_nibble_sequencer_pkg::*;
(
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   input  logic             c0,
   output logic [NIB_W-1:0] f,
   output logic             c4
);

   logic [NIB_W-1:0] p;
   logic [NIB_W-1:0] g;
   logic [NIB_W:0]   c;

   assign p = a ^ b;
   assign g = a & b;

   // every carry is a flat sum of products of c0, so no ripple through the slice
   assign c[0] = c0;
   assign c[1] = g[0] | (p[0] & c0);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & c0);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c0);

   assign f  = p ^ c[NIB_W-1:0];
   assign c4 = c[NIB_W];

endmodule

// File: rtl/cla_nibble_sequencer.sv
// rtl/cla_nibble_sequencer.sv - wide add/sub built by cycling operands through one 4-bit CLA slice
module cla_nibble_sequencer
   import cla_nibble_sequencer_pkg::*;
#(
   parameter int WIDTH = 16
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NNIB  = WIDTH / NIB_W;
   localparam int IDX_W = (NNIB > 1) ? $clog2(NNIB) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NNIB - 1);

   logic [1:0]       state;
   logic [IDX_W-1:0] idx;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             carry;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;

   logic [NIB_W-1:0] a_nib;
   logic [NIB_W-1:0] b_nib;
   logic [NIB_W-1:0] f;
   logic             c4;
   logic             accept;

   assign a_nib  = a_q[idx*NIB_W +: NIB_W];
   assign b_nib  = b_q[idx*NIB_W +: NIB_W];
   assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));

   cla4_slice u_slice (
      .a  (a_nib),
      .b  (b_nib),
      .c0 (carry),
      .f  (f),
      .c4 (c4)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         idx    <= '0;
         a_q    <= '0;
         b_q    <= '0;
         carry  <= 1'b0;
         sum_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (accept) begin
         // subtraction is a + ~b + 1, so B is inverted once here and carry seeds the +1
         a_q   <= a;
         b_q   <= sub ? ~b : b;
         carry <= sub ? 1'b1 : cin;
         idx   <= '0;
         state <= ST_RUN;
      end else begin
         case (state)
            ST_RUN: begin
               sum_q[idx*NIB_W +: NIB_W] <= f;
               carry <= c4;
               if (idx == LAST_IDX) begin
                  cout_q <= c4;
                  ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (f[NIB_W-1] != a_q[WIDTH-1]);
                  idx    <= '0;
                  state  <= ST_DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy = (state == ST_RUN);
   assign done = (state == ST_DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// tb/tb_cla_nibble_sequencer.sv - self-checking bench for cla_nibble_sequencer
module tb_cla_nibble_sequencer;

   localparam int W  = 16;
   localparam int NN = W / 4;

   logic         clk   = 1'b0;
   logic         rst   = 1'b1;
   logic         start = 1'b0;
   logic         sub   = 1'b0;
   logic         cin   = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int n_checks = 0;
   int n_fail   = 0;

   cla_nibble_sequencer #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .sub   (sub),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // arithmetic reference: integer add/subtract, then read off modulo result, carry and signed range
   function automatic void ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input bit c, input bit s,
                                  output logic [W-1:0] r, output bit co, output bit ov);
      longint sx, sy, sr, ux, uy, ur;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = longint'(x);
      uy = longint'(y);
      if (s) begin
         sr = sx - sy;
         ur = ux - uy;
         co = (ux >= uy);
      end else begin
         sr = sx + sy + longint'(c);
         ur = ux + uy + longint'(c);
         co = ((ur >> W) & 1) != 0;
      end
      r  = ur[W-1:0];
      ov = (sr > (longint'(1) <<< (W-1)) - 1) || (sr < -(longint'(1) <<< (W-1)));
   endfunction

   int           m_left = 0;
   bit           m_done = 0;
   logic [W-1:0] m_sum  = '0;
   bit           m_cout = 0;
   bit           m_ovf  = 0;
   logic [W-1:0] p_sum  = '0;
   bit           p_cout = 0;
   bit           p_ovf  = 0;

   always @(posedge clk or posedge rst) begin
      bit acc;
      if (rst) begin
         m_left = 0;
         m_done = 0;
         m_sum  = '0;
         m_cout = 0;
         m_ovf  = 0;
      end else begin
         acc    = start && (m_left == 0);
         m_done = 0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_done = 1;
               m_sum  = p_sum;
               m_cout = p_cout;
               m_ovf  = p_ovf;
            end
         end
         if (acc) begin
            ref_op(a, b, cin, sub, p_sum, p_cout, p_ovf);
            m_left = NN;
         end
      end
   end

   always @(negedge clk) begin
      chk("busy", 32'(busy), 32'(m_left > 0));
      chk("done", 32'(done), 32'(m_done));
      if (m_left == 0) begin
         chk("sum",  32'(sum),  32'(m_sum));
         chk("cout", 32'(cout), 32'(m_cout));
         chk("ovf",  32'(ovf),  32'(m_ovf));
      end
   end

   task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input bit tc, input bit ts);
      a     = ta;
      b     = tb;
      cin   = tc;
      sub   = ts;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      cin   = 1'($urandom_range(0, 1));
      sub   = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (done) break;
         if (cyc > 20) begin
            chk("done_timeout", 32'(cyc), 32'(NN + 1));
            break;
         end
      end
   endtask

   task automatic directed(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input bit tc, input bit ts,
                           input logic [W-1:0] es, input bit ec, input bit eo);
      int cyc;
      start_op(ta, tb, tc, ts);
      wait_done(cyc);
      chk({nm, "_latency"}, 32'(cyc), 32'(NN + 1));
      chk({nm, "_sum"},     32'(sum),  32'(es));
      chk({nm, "_cout"},    32'(cout), 32'(ec));
      chk({nm, "_ovf"},     32'(ovf),  32'(eo));
      chk({nm, "_model"},   32'(m_sum), 32'(es));
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return 16'h8000;
         3:       return 16'h7FFF;
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      int cyc;
      int extra;

      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_sum",  32'(sum),  32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      directed("add",     16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
      directed("ripple",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
      directed("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      directed("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      directed("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

      // start while busy must be dropped
      @(posedge clk);
      #1;
      start_op(16'h1000, 16'h0234, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      a     = 16'hAAAA;
      b     = 16'h5555;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(cyc);
      chk("ignored_latency", 32'(cyc), 32'd3);
      chk("ignored_sum",     32'(sum), 32'h1234);

      // back-to-back: start presented during the done cycle
      start_op(16'h0F0F, 16'h0101, 1'b1, 1'b0);
      wait_done(cyc);
      chk("b2b_latency", 32'(cyc), 32'(NN + 1));
      chk("b2b_sum",     32'(sum), 32'h1011);
      extra = 0;
      repeat (6) begin
         @(negedge clk);
         if (done) extra++;
      end
      chk("b2b_single_done", 32'(extra), 32'h0);

      // asynchronous reset in the middle of an operation
      @(posedge clk);
      #1;
      start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("arst_busy", 32'(busy), 32'h0);
      chk("arst_done", 32'(done), 32'h0);
      chk("arst_sum",  32'(sum),  32'h0);
      chk("arst_cout", 32'(cout), 32'h0);
      chk("arst_ovf",  32'(ovf),  32'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      extra = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) extra++;
      end
      chk("arst_no_done", 32'(extra), 32'h0);
      @(posedge clk);
      #1;
      directed("after_rst", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);

      // random traffic, including starts that land while busy
      repeat (3000) begin
         @(posedge clk);
         #1;
         start = ($urandom_range(0, 3) == 0);
         a     = pick();
         b     = pick();
         cin   = 1'($urandom_range(0, 1));
         sub   = 1'($urandom_range(0, 1));
      end
      start = 1'b0;
      repeat (NN + 4) @(posedge clk);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
